// File: rtl/approx_prod_accum.sv
// Sums a frame of unsigned products into a wide accumulator. With ACC_SAT_EN, overflow clamps to all-ones; otherwise the sum wraps.
// The result is valid 1 cycle after the closing beat. Input stalls (in_ready=0) while a result waits; one bubble after the result handshake.
module approx_prod_accum #(
   parameter int PROD_W    = 16,
   parameter int ACC_W     = 24,
   parameter int MAX_TERMS = 16,
   localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   typedef enum logic {S_ACC = 1'b0, S_DONE = 1'b1} state_t;

   state_t            r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_out_valid;

   logic [ACC_W-1:0]  w_prod_ext;
   logic [ACC_W:0]    w_sum;
   logic              w_carry;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_close;

   assign w_prod_ext = ACC_W'(in_prod);
   assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
   assign w_carry    = w_sum[ACC_W];
`ifdef ACC_SAT_EN
   // Once clamped, any further non-zero add carries again, so the clamp holds.
   assign w_acc_nxt  = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_acc_nxt  = w_sum[ACC_W-1:0];
`endif
   assign w_cnt_nxt  = r_cnt + 1'b1;
   assign w_close    = in_last || (w_cnt_nxt == CNT_W'(MAX_TERMS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (clear) begin
         r_state     <= S_ACC;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_ACC: begin
               if (in_valid) begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= w_cnt_nxt;
                  r_ovf <= r_ovf | w_carry;
                  if (w_close) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_ACC;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_ovf       <= 1'b0;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_ACC;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == S_ACC);
   assign out_valid = r_out_valid;
   assign out_sum   = r_acc;
   assign out_count = r_cnt;
   assign out_ovf   = r_ovf;

endmodule
